// File: rtl/arb_ingress_queues_if.sv
// arb_ingress_queues_if: ingress, arbiter and egress signal bundle for arb_ingress_queues
interface arb_ingress_queues_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    localparam int IW = $clog2(N);
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    arb_req;
    logic            arb_en;
    logic [N-1:0]    arb_grant;
    logic [IW-1:0]   arb_grant_id;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_ready;
    logic            err;
    modport slave (
        input  in_valid, in_data, arb_grant, arb_grant_id, out_ready,
        output in_ready, arb_req, arb_en, out_valid, out_data, out_id, err
    );
    modport master (
        output in_valid, in_data, arb_grant, arb_grant_id, out_ready,
        input  in_ready, arb_req, arb_en, out_valid, out_data, out_id, err
    );
endinterface

// File: rtl/arb_ingress_queues.sv
// arb_ingress_queues: per-requester ingress FIFOs feeding a round-robin arbiter through a 2-entry output buffer
// Optional ARB_INGRESS_GRANT_CNT_EN adds grant_cnt, a saturating 16-bit pop counter per requester.
module arb_ingress_queues #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rstn,
    arb_ingress_queues_if.slave bus
`ifdef ARB_INGRESS_GRANT_CNT_EN
    ,
    output logic [N*16-1:0] grant_cnt
`endif
);
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    logic [N-1:0]     live, push, pop, empty, rdy, req;
    logic [DW-1:0]    head [N];
    logic [DW-1:0]    pd;
    logic             gv, err_q, ob_push, ob_pop, hit_empty;
    logic [1:0]       ob_cnt;
    logic             ob_wp, ob_rp;
    logic [IW+DW-1:0] ob_mem [2];

    // the arbiter holds stale grants while disabled, so only a grant following an enabled cycle counts
    assign live      = gv ? bus.arb_grant : '0;
    assign pop       = live & ~empty;
    assign hit_empty = |(live & empty);
    assign ob_push   = |pop;
    assign ob_pop    = bus.out_valid && bus.out_ready;
    // reserve a buffer slot for the grant that lands next cycle; a concurrent output pop is not credited
    assign bus.arb_en    = ({1'b0, ob_cnt} + {2'b0, |live}) <= 3'd1;
    assign bus.out_valid = ob_cnt != 2'd0;
    assign {bus.out_id, bus.out_data} = ob_mem[ob_rp];
    assign bus.err      = err_q;
    assign bus.in_ready = rdy;
    assign bus.arb_req  = req;

    for (genvar g = 0; g < N; g++) begin : q
        logic [DW-1:0] mem [DEPTH];
        logic [AW-1:0] wp, rp;
        logic [AW:0]   occ;
        assign empty[g] = occ == '0;
        assign rdy[g]   = occ != (AW+1)'(DEPTH);
        assign push[g]  = bus.in_valid[g] && rdy[g];
        // the entry being popped no longer requests, so a single entry is never granted twice
        assign req[g]   = (occ - {{AW{1'b0}}, live[g]}) != '0;
        assign head[g]  = mem[rp];
        // pointers and occupancy; push and pop together leave occ unchanged
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wp  <= '0;
                rp  <= '0;
                occ <= '0;
            end else begin
                if (push[g]) wp <= wp + 1'b1;
                if (pop[g]) rp <= rp + 1'b1;
                occ <= occ + {{AW{1'b0}}, push[g]} - {{AW{1'b0}}, pop[g]};
            end
        end
        // payload storage, only ever read behind a nonzero occupancy
        always_ff @(posedge clk) begin
            if (push[g]) mem[wp] <= bus.in_data[g*DW +: DW];
        end
`ifdef ARB_INGRESS_GRANT_CNT_EN
        logic [15:0] gc;
        // saturating count of successful pops from this FIFO
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) gc <= '0;
            else if (pop[g] && gc != 16'hFFFF) gc <= gc + 16'd1;
        end
        assign grant_cnt[g*16 +: 16] = gc;
`endif
    end

    // AND-OR select of the granted FIFO head (live grant is one-hot)
    always_comb begin
        pd = '0;
        for (int i = 0; i < N; i++) pd |= pop[i] ? head[i] : '0;
    end

    // output buffer, registered arbiter enable and sticky empty-grant error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ob_mem <= '{default: '0};
            ob_wp  <= 1'b0;
            ob_rp  <= 1'b0;
            ob_cnt <= 2'd0;
            gv     <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            gv    <= bus.arb_en;
            err_q <= err_q | hit_empty;
            if (ob_push) begin
                ob_mem[ob_wp] <= {bus.arb_grant_id, pd};
                ob_wp         <= ~ob_wp;
            end
            if (ob_pop) ob_rp <= ~ob_rp;
            ob_cnt <= ob_cnt + {1'b0, ob_push} - {1'b0, ob_pop};
        end
    end
endmodule
